uart_tx_arb: RTL
================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 The block SHALL have parameter DCNT_W, default 8, giving the width of the echo drop counter.
REQ-002 The block SHALL have parameter ECHO_DROP, default 1; 1 = echo requester never stalls (overwrite/drop), 0 = echo uses normal ready handshake.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req0_char  input  8  monitor character (requester 0).
REQ-006 req0_valid  input  1  requester 0 offers req0_char.
REQ-007 req0_ready  output  1  requester 0 slot free.
REQ-008 req1_char / req1_valid / req1_ready  input 8 / input 1 / output 1  CPU uart_io requester 1, same semantics.
REQ-009 req2_char / req2_valid / req2_ready  input 8 / input 1 / output 1  rx echo-back requester 2, same semantics.
REQ-010 tx_wdata  output  8  character to TX FIFO.
REQ-011 tx_wten  output  1  one-cycle TX FIFO write strobe.
REQ-012 tx_fifo_full  input  1  TX FIFO full flag.
REQ-013 flush  input  1  synchronous clear of all held characters.
REQ-014 drop_cnt  output  DCNT_W  saturating count of echo characters lost.
REQ-015 drop_clr  input  1  synchronous clear of drop_cnt.

Function
REQ-016 Each requester i SHALL own a one-entry holding register (hold_v[i], hold_d[i]); reqi_ready = ~hold_v[i] (for i=2 with ECHO_DROP=1, req2_ready SHALL be constant 1).
REQ-017 A transfer SHALL occur on a rising edge with reqi_valid & reqi_ready; hold_v[i] set, hold_d[i] = reqi_char on that edge.
REQ-018 Grant condition per cycle: any hold_v set, tx_fifo_full = 0, tx_wten = 0, flush = 0.
REQ-019 Grant SHALL be round-robin: search order starts at (last_grant+1) mod 3, wraps 2->0; first set hold_v wins; last_grant updated to winner.
REQ-020 On a grant edge: tx_wten <= 1, tx_wdata <= hold_d[winner], hold_v[winner] <= 0; otherwise tx_wten <= 0, tx_wdata holds value.
REQ-021 tx_wten SHALL never be high on two consecutive cycles (max one write per 2 clocks) so tx_fifo_full always reflects the previous write.
REQ-022 Latency: character accepted at edge k SHALL, with FIFO not full and no competition, produce tx_wten high in the cycle after edge k+1.
REQ-023 Simultaneous grant of i and new transfer on i in the same edge: hold_v[i] SHALL remain 1 with the new character (ready is low then, so only reachable for echo with ECHO_DROP=1).
REQ-024 ECHO_DROP=1: req2_valid while hold_v[2]=1 and requester 2 not granted that edge SHALL overwrite hold_d[2] and increment drop_cnt.
REQ-025 drop_cnt SHALL saturate at all-ones; drop_clr SHALL zero it, taking priority over a same-cycle increment.
REQ-026 tx_fifo_full high SHALL stall all grants indefinitely; holds and last_grant unchanged.
REQ-027 flush SHALL clear all hold_v on that edge, suppress grant and any same-edge transfer; tx_wten <= 0; last_grant and drop_cnt unchanged.

Reset
REQ-028 On rst_n low, asynchronously: hold_v = 0, hold_d = 0, tx_wten = 0, tx_wdata = 8'h00, last_grant = 2 (requester 0 first), drop_cnt = 0.
REQ-029 Reset asserted mid-operation SHALL discard held characters; after deassert all readys (req0/req1, and req2 when ECHO_DROP=0) are 1 in the first cycle.

Verification
REQ-030 Single: req1 'A'(8'h41) at edge k, FIFO empty -> tx_wten one cycle after edge k+1, tx_wdata 8'h41, req1_ready high again.
REQ-031 Contention: all three hold 8'h30/8'h31/8'h32 after reset -> writes in order 30,31,32 with one idle cycle between strobes.
REQ-032 Full stall: tx_fifo_full=1 for 20 cycles with req0 held -> no tx_wten, req0_ready=0; full drops -> write within 2 cycles.
REQ-033 Echo drop: FIFO full, req2 pulses 8'h61,8'h62,8'h63 -> drop_cnt=2, released write is 8'h63; drop_clr -> 0.
REQ-034 Saturation: DCNT_W=2, 5 drops -> drop_cnt=3.
REQ-035 Flush/reset: flush with all holds set -> no write follows, all readys 1; repeat with rst_n pulse mid-contention -> outputs at reset values.

Source files
------------

// File: rtl/uart_tx_arb_if.sv
// Bundle of requester handshakes and TX FIFO write port for uart_tx_arb.
// The arbiter takes the slave side; the requesters and FIFO model take the master side.
interface uart_tx_arb_if #(
    parameter int DCNT_W = 8
);
    logic [7:0]        req0_char;
    logic              req0_valid;
    logic              req0_ready;
    logic [7:0]        req1_char;
    logic              req1_valid;
    logic              req1_ready;
    logic [7:0]        req2_char;
    logic              req2_valid;
    logic              req2_ready;
    logic [7:0]        tx_wdata;
    logic              tx_wten;
    logic              tx_fifo_full;
    logic              flush;
    logic [DCNT_W-1:0] drop_cnt;
    logic              drop_clr;

    modport master (
        output req0_char, req0_valid, req1_char, req1_valid, req2_char, req2_valid,
        output tx_fifo_full, flush, drop_clr,
        input  req0_ready, req1_ready, req2_ready, tx_wdata, tx_wten, drop_cnt
    );

    modport slave (
        input  req0_char, req0_valid, req1_char, req1_valid, req2_char, req2_valid,
        input  tx_fifo_full, flush, drop_clr,
        output req0_ready, req1_ready, req2_ready, tx_wdata, tx_wten, drop_cnt
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Three-way round-robin arbiter feeding one character per two clocks into a UART TX FIFO,
// with one holding register per requester and an optional lossy echo path.
module uart_tx_arb #(
    parameter int DCNT_W    = 8,
    parameter bit ECHO_DROP = 1'b1
) (
    input logic         clk,
    input logic         rst_n,
    uart_tx_arb_if.slave bus
);
    logic [2:0]        hold_v_q, hold_v_d;
    logic [7:0]        hold_d_q [3];
    logic [7:0]        hold_d_d [3];
    logic [1:0]        last_q, last_d;
    logic              wten_q, wten_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [DCNT_W-1:0] drop_q, drop_d;

    logic [2:0] valid, ready, take, gnt;
    logic [7:0] chr [3];
    logic [1:0] win;
    logic       grant_ok;

    function automatic logic [DCNT_W-1:0] sat_inc(input logic [DCNT_W-1:0] v);
        return (&v) ? v : v + DCNT_W'(1);
    endfunction

    // Walk from farthest to nearest candidate so the nearest set entry is the one kept.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] v);
        logic [1:0] c;
        logic [1:0] w;
        w = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            c = 2'((int'(last) + k) % 3);
            if (v[c]) w = c;
        end
        return w;
    endfunction

    assign valid  = {bus.req2_valid, bus.req1_valid, bus.req0_valid};
    assign chr[0] = bus.req0_char;
    assign chr[1] = bus.req1_char;
    assign chr[2] = bus.req2_char;

    assign ready[0] = ~hold_v_q[0];
    assign ready[1] = ~hold_v_q[1];
    assign ready[2] = ECHO_DROP ? 1'b1 : ~hold_v_q[2];

    // Blocking on wten_q guarantees the FIFO full flag already reflects the previous write.
    assign grant_ok = (|hold_v_q) & ~bus.tx_fifo_full & ~wten_q & ~bus.flush;

    always_comb begin
        win      = rr_pick(last_q, hold_v_q);
        gnt      = grant_ok ? (3'b001 << win) : 3'b000;
        take     = valid & ready & {3{~bus.flush}};
        hold_v_d = hold_v_q;
        hold_d_d = hold_d_q;
        last_d   = grant_ok ? win : last_q;
        wten_d   = grant_ok;
        wdata_d  = grant_ok ? hold_d_q[win] : wdata_q;
        drop_d   = drop_q;
        for (int i = 0; i < 3; i++) begin
            if (gnt[i]) hold_v_d[i] = 1'b0;
            if (take[i]) begin
                hold_v_d[i] = 1'b1;
                hold_d_d[i] = chr[i];
            end
        end
        if (bus.flush) hold_v_d = 3'b000;
        if (ECHO_DROP && take[2] && hold_v_q[2] && !gnt[2]) drop_d = sat_inc(drop_q);
        if (bus.drop_clr) drop_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_v_q <= 3'b000;
            for (int i = 0; i < 3; i++) hold_d_q[i] <= 8'h00;
            last_q   <= 2'd2;
            wten_q   <= 1'b0;
            wdata_q  <= 8'h00;
            drop_q   <= '0;
        end else begin
            hold_v_q <= hold_v_d;
            hold_d_q <= hold_d_d;
            last_q   <= last_d;
            wten_q   <= wten_d;
            wdata_q  <= wdata_d;
            drop_q   <= drop_d;
        end
    end

    assign bus.req0_ready = ready[0];
    assign bus.req1_ready = ready[1];
    assign bus.req2_ready = ready[2];
    assign bus.tx_wten    = wten_q;
    assign bus.tx_wdata   = wdata_q;
    assign bus.drop_cnt   = drop_q;
endmodule
